// File: rtl/key_sweep_pkg.sv
// Purpose : shared widths, saturation limits and FSM state encoding for the key sweep controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package key_sweep_pkg;

    localparam int KEY_W  = 32;
    localparam int OP_W   = 16;
    localparam int SUM_W  = 17;
    localparam int ERR_W  = 16;
    localparam int FLIP_W = 24;
    localparam int PC_W   = 5;     // popcount of a SUM_W-bit vector fits in 5 bits

    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [FLIP_W-1:0] FLIP_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETTLE,
        ST_CHECK,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/key_sweep_ctrl_if.sv
// Purpose : key / operand-pair / report handshakes between a sweep driver and key_sweep_ctrl.
// Latency : n/a (wires only).
// Backpr. : each channel is valid/ready; a transfer happens on a cycle where both are high.
// Ports   : key_valid/key_ready/key_i, op_valid/op_ready/op_a_i/op_b_i,
//           rpt_valid/rpt_ready/rpt_key/rpt_err_cnt/rpt_flip_cnt.
interface key_sweep_ctrl_if;
    import key_sweep_pkg::*;

    logic              key_valid;
    logic              key_ready;
    logic [KEY_W-1:0]  key_i;

    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   op_a_i;
    logic [OP_W-1:0]   op_b_i;

    logic              rpt_valid;
    logic              rpt_ready;
    logic [KEY_W-1:0]  rpt_key;
    logic [ERR_W-1:0]  rpt_err_cnt;
    logic [FLIP_W-1:0] rpt_flip_cnt;

    // Driver side: offers keys and operand pairs, consumes reports.
    modport master (
        output key_valid, key_i, op_valid, op_a_i, op_b_i, rpt_ready,
        input  key_ready, op_ready, rpt_valid, rpt_key, rpt_err_cnt, rpt_flip_cnt
    );

    // Controller side.
    modport slave (
        input  key_valid, key_i, op_valid, op_a_i, op_b_i, rpt_ready,
        output key_ready, op_ready, rpt_valid, rpt_key, rpt_err_cnt, rpt_flip_cnt
    );

endinterface

// File: rtl/hd_popcount17.sv
// Purpose : Hamming weight of the 17-bit sum difference.
// Latency : combinational, 0 cycles.
// Backpr. : none.
// Ports   : diff_i (17b in), cnt_o (5b out).
module hd_popcount17
    import key_sweep_pkg::*;
(
    input  logic [SUM_W-1:0] diff_i,
    output logic [PC_W-1:0]  cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < SUM_W; i++) begin
            cnt_o = cnt_o + {{(PC_W-1){1'b0}}, diff_i[i]};
        end
    end

endmodule

// File: rtl/key_sweep_ctrl.sv
// Purpose : applies N_PAIRS operand pairs per candidate key to an external locked adder and
//           reports mismatching pairs and total flipped sum bits.
// Latency : per pair 1 + SETTLE + 1 cycles from operand accept to result sample.
// Backpr. : stalls in FETCH without op_valid; holds report until rpt_ready; abort/rst drop the sweep.
// Ports   : clk, rst, bus (slave handshakes), abort, add1_o/add2_o/keyinput_o to the adder, result_i from it.
module key_sweep_ctrl
    import key_sweep_pkg::*;
#(
    parameter int N_PAIRS = 5000,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    key_sweep_ctrl_if.slave    bus,
    input  logic               abort,
    output logic [OP_W-1:0]    add1_o,
    output logic [OP_W-1:0]    add2_o,
    output logic [KEY_W-1:0]   keyinput_o,
    input  logic [SUM_W-1:0]   result_i
);

    state_t             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [OP_W-1:0]    add1_q;
    logic [OP_W-1:0]    add2_q;
    logic [SUM_W-1:0]   golden_q;
    logic [3:0]         settle_cnt_q;
    logic [15:0]        pair_cnt_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [FLIP_W-1:0]  flip_cnt_q;
    logic               key_ready_q;
    logic               op_ready_q;
    logic               rpt_valid_q;

    logic [SUM_W-1:0]   diff;
    logic [PC_W-1:0]    diff_pc;
    logic [FLIP_W:0]    flip_sum;
    logic [ERR_W-1:0]   err_cnt_d;
    logic [FLIP_W-1:0]  flip_cnt_d;
    logic               last_pair;

    // Counter updates for the CHECK cycle; both saturate instead of wrapping.
    assign diff       = result_i ^ golden_q;
    assign flip_sum   = {1'b0, flip_cnt_q} + {{(FLIP_W+1-PC_W){1'b0}}, diff_pc};
    assign flip_cnt_d = flip_sum[FLIP_W] ? FLIP_MAX : flip_sum[FLIP_W-1:0];
    assign err_cnt_d  = ((|diff) && (err_cnt_q != ERR_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q;
    assign last_pair  = ({1'b0, pair_cnt_q} + 17'd1) == 17'(N_PAIRS);

    hd_popcount17 u_popcount (
        .diff_i (diff),
        .cnt_o  (diff_pc)
    );

    // Handshake outputs are loaded alongside each state transition, so they are
    // registered decodes of the state with no path from any valid/ready input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            add1_q       <= '0;
            add2_q       <= '0;
            golden_q     <= '0;
            settle_cnt_q <= '0;
            pair_cnt_q   <= '0;
            err_cnt_q    <= '0;
            flip_cnt_q   <= '0;
            key_ready_q  <= 1'b1;
            op_ready_q   <= 1'b0;
            rpt_valid_q  <= 1'b0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            pair_cnt_q   <= '0;
            err_cnt_q    <= '0;
            flip_cnt_q   <= '0;
            key_ready_q  <= 1'b1;
            op_ready_q   <= 1'b0;
            rpt_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.key_valid && key_ready_q) begin
                        key_q       <= bus.key_i;
                        pair_cnt_q  <= '0;
                        err_cnt_q   <= '0;
                        flip_cnt_q  <= '0;
                        state_q     <= ST_FETCH;
                        key_ready_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bus.op_valid && op_ready_q) begin
                        add1_q       <= bus.op_a_i;
                        add2_q       <= bus.op_b_i;
                        golden_q     <= {1'b0, bus.op_a_i} + {1'b0, bus.op_b_i};
                        settle_cnt_q <= '0;
                        state_q      <= ST_SETTLE;
                        op_ready_q   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == 4'(SETTLE - 1)) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    err_cnt_q  <= err_cnt_d;
                    flip_cnt_q <= flip_cnt_d;
                    pair_cnt_q <= pair_cnt_q + 1'b1;
                    if (last_pair) begin
                        state_q     <= ST_REPORT;
                        rpt_valid_q <= 1'b1;
                    end else begin
                        state_q    <= ST_FETCH;
                        op_ready_q <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (bus.rpt_ready && rpt_valid_q) begin
                        state_q     <= ST_IDLE;
                        rpt_valid_q <= 1'b0;
                        key_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    key_ready_q <= 1'b1;
                    op_ready_q  <= 1'b0;
                    rpt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign add1_o           = add1_q;
    assign add2_o           = add2_q;
    assign keyinput_o       = key_q;
    assign bus.key_ready    = key_ready_q;
    assign bus.op_ready     = op_ready_q;
    assign bus.rpt_valid    = rpt_valid_q;
    assign bus.rpt_key      = key_q;
    assign bus.rpt_err_cnt  = err_cnt_q;
    assign bus.rpt_flip_cnt = flip_cnt_q;

endmodule
